dma_reader: RTL and testbench

Read-side DMA for the IO path. On a start pulse it fetches one row (rowSize/blockSize words) from the on-chip RAM, beginning at a latched base address. It streams the words out one blockSize-bit section at a time over a valid/ready handshake. It is the reverse of the write DMA, which packs decompressed rows into RAM, and it drains CNN results from RAM toward the output interface.

---
 rtl/dma_reader.sv | 99 +++++++++
 tb/tb_dma_reader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dma_reader.sv
// dma_reader: fetches one row of RAM words from a latched base address and streams them out over valid/ready.
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start             request one row (sampled only when idle)
//   base_address      first RAM address of the row, latched on start
//   ram_enable        RAM read strobe (one cycle per word)
//   ram_write         always 0, this block only reads
//   ram_address       RAM address, base + word index modulo 2^addr_width
//   ram_data          RAM read data, valid the cycle after ram_enable
//   out_section       current output word
//   out_valid         out_section is valid
//   out_ready         downstream accepts out_section
//   busy              high whenever not idle
//   done              one-cycle pulse after the last word is accepted
module dma_reader #(
    parameter int block_size = 16,
    parameter int row_size   = 512,
    parameter int addr_width = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [addr_width-1:0] base_address,
    output logic                  ram_enable,
    output logic                  ram_write,
    output logic [addr_width-1:0] ram_address,
    input  logic [block_size-1:0] ram_data,
    output logic [block_size-1:0] out_section,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);
    localparam int n = row_size / block_size;
    // One spare bit so the index width is never zero and i+1 never overflows.
    localparam int iw = $clog2(n + 1);
    localparam logic [iw-1:0] last = iw'(n - 1);

    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, SEND, DONE} state_t;

    state_t                state;
    logic [iw-1:0]         i;
    logic [addr_width-1:0] base;

    assign ram_write = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            i           <= '0;
            base        <= '0;
            ram_enable  <= 1'b0;
            ram_address <= '0;
            out_section <= '0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    base        <= base_address;
                    i           <= '0;
                    ram_enable  <= 1'b1;
                    ram_address <= base_address;
                    busy        <= 1'b1;
                    state       <= FETCH;
                end
                FETCH: begin
                    ram_enable <= 1'b0;
                    state      <= CAPTURE;
                end
                CAPTURE: begin
                    out_section <= ram_data;
                    out_valid   <= 1'b1;
                    state       <= SEND;
                end
                SEND: if (out_ready) begin
                    out_valid <= 1'b0;
                    if (i == last) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        // Address of the next word is issued together with the FETCH state.
                        i           <= i + 1'b1;
                        ram_enable  <= 1'b1;
                        ram_address <= base + addr_width'(i + 1'b1);
                        state       <= FETCH;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_reader.sv
// tb_dma_reader: randomized self-checking bench for dma_reader against a cycle-level behavioural model.
module tb_dma_reader;
    localparam int N = 32;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b1;
    logic [15:0] base_address = '0, ram_data = '0;
    logic        ram_enable, ram_write, out_valid, busy, done;
    logic [15:0] ram_address, out_section;
    logic [15:0] mem [0:65535];

    int checks = 0, failures = 0;

    // behavioural model state, written only by the monitor
    int          t = 0, t_acc = 0, fetch_at = -10, done_at = -10, stalls = 0, m_k = 0;
    bit          m_active = 1'b0;
    logic [15:0] m_base = '0;
    logic [15:0] addr_log[$], sec_log[$];
    int          done_log[$], fetch_log[$];

    dma_reader dut (
        .clk(clk), .rst(rst), .start(start), .base_address(base_address),
        .ram_enable(ram_enable), .ram_write(ram_write), .ram_address(ram_address),
        .ram_data(ram_data), .out_section(out_section), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_enable && !ram_write) ram_data <= mem[ram_address];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, got, exp, t);
        end
    endtask

    // Model: each word is fetched the cycle after acceptance/previous handshake,
    // presented two cycles later until accepted; done follows the last acceptance.
    always @(negedge clk) begin
        bit          exp_en, exp_val;
        logic [15:0] a;
        t++;
        if (rst) begin
            m_active = 1'b0;
            done_at  = -10;
            chk("rst_ctrl", {ram_enable, ram_write, out_valid, busy, done}, 0);
            chk("rst_addr", ram_address, 0);
            chk("rst_section", out_section, 0);
        end else begin
            a       = m_base + 16'(m_k);
            exp_en  = m_active && t == fetch_at;
            exp_val = m_active && t >= fetch_at + 2;
            chk("ram_enable", ram_enable, exp_en);
            chk("ram_write", ram_write, 0);
            chk("out_valid", out_valid, exp_val);
            chk("done", done, t == done_at);
            chk("busy", busy, m_active || t == done_at);
            if (exp_en) begin
                chk("ram_address", ram_address, a);
                addr_log.push_back(ram_address);
                fetch_log.push_back(t);
            end
            if (exp_val) chk("out_section", out_section, mem[a]);
            if (done) done_log.push_back(t - t_acc);
            if (!m_active && t != done_at && start) begin
                m_active = 1'b1;
                m_base   = base_address;
                m_k      = 0;
                fetch_at = t + 1;
                t_acc    = t;
                stalls   = 0;
            end else if (exp_val && out_ready) begin
                sec_log.push_back(out_section);
                if (m_k == N - 1) begin
                    m_active = 1'b0;
                    done_at  = t + 1;
                end else begin
                    m_k++;
                    fetch_at = t + 1;
                end
            end else if (exp_val) stalls++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready high, 1: 5-cycle stall on word 7 and toggling elsewhere,
    // 2: random ready, 3: ready high with start pulses at word 10 and in DONE
    task automatic run_row(input logic [15:0] b, input int mode);
        int n_done = done_log.size();
        int st7 = 0;
        bit p1 = 1'b0, p2 = 1'b0, fin = 1'b0;
        base_address = b;
        start = 1'b1;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 3000 && !fin; c++) begin
            case (mode)
                1: if (out_valid && m_k == 7 && st7 < 5) begin
                       out_ready = 1'b0;
                       st7++;
                   end else out_ready = (m_k == 7) ? 1'b1 : 1'($urandom_range(0, 1));
                2: out_ready = $urandom_range(0, 3) != 0;
                3: begin
                    out_ready = 1'b1;
                    start = 1'b0;
                    if (!p1 && out_valid && m_k == 10) begin
                        start = 1'b1;
                        base_address = 16'h5555;
                        p1 = 1'b1;
                    end
                    if (!p2 && done) begin
                        start = 1'b1;
                        p2 = 1'b1;
                    end
                end
                default: out_ready = 1'b1;
            endcase
            step();
            fin = done_log.size() > n_done && !busy;
        end
        start = 1'b0;
        out_ready = 1'b1;
        if (!fin) chk("row_timeout", 1, 0);
    endtask

    initial begin
        int a0, s0, d0, f0;
        bit fin;
        for (int a = 0; a < 65536; a++) mem[a] = 16'(a * 40503 + 4660);
        for (int k = 0; k < N; k++) mem[100 + k] = 16'(k * 3);
        repeat (3) step();
        chk("reset_ctrl", {ram_enable, ram_write, out_valid, busy, done}, 0);
        chk("reset_data", {ram_address, out_section}, 0);
        rst = 1'b0;
        step();

        // basic row
        a0 = addr_log.size(); s0 = sec_log.size(); d0 = done_log.size();
        run_row(16'd100, 0);
        chk("basic_count", sec_log.size() - s0, 32);
        chk("basic_sec0", sec_log[s0], 0);
        chk("basic_sec1", sec_log[s0 + 1], 3);
        chk("basic_sec31", sec_log[s0 + 31], 93);
        chk("basic_addr0", addr_log[a0], 100);
        chk("basic_addr31", addr_log[a0 + 31], 131);
        chk("basic_done_count", done_log.size() - d0, 1);
        chk("basic_done_cycle", done_log[d0], 97);

        // backpressure
        s0 = sec_log.size(); d0 = done_log.size();
        run_row(16'd100, 1);
        chk("bp_count", sec_log.size() - s0, 32);
        for (int k = 0; k < N; k++) chk("bp_sec", sec_log[s0 + k], k * 3);
        chk("bp_stalls_min", stalls >= 5, 1);
        chk("bp_done_cycle", done_log[d0], 97 + stalls);

        // address wrap
        a0 = addr_log.size(); s0 = sec_log.size();
        run_row(16'hFFF0, 2);
        chk("wrap_addr0", addr_log[a0], 16'hFFF0);
        chk("wrap_addr15", addr_log[a0 + 15], 16'hFFFF);
        chk("wrap_addr16", addr_log[a0 + 16], 16'h0000);
        chk("wrap_addr31", addr_log[a0 + 31], 16'h000F);
        chk("wrap_sec16", sec_log[s0 + 16], mem[0]);

        // start while busy
        a0 = addr_log.size(); d0 = done_log.size();
        run_row(16'd200, 3);
        repeat (5) step();
        chk("sb_done_count", done_log.size() - d0, 1);
        chk("sb_fetch_count", addr_log.size() - a0, 32);
        chk("sb_addr31", addr_log[a0 + 31], 231);
        chk("sb_idle", busy, 0);

        // reset mid-row
        d0 = done_log.size();
        base_address = 16'd300;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 500 && !(out_valid && m_k == 12); c++) step();
        chk("rm_reached_word12", out_valid && m_k == 12, 1);
        #1 rst = 1'b1;
        #1;
        chk("rm_async_ctrl", {ram_enable, out_valid, busy, done}, 0);
        chk("rm_async_data", {ram_address, out_section}, 0);
        step();
        rst = 1'b0;
        repeat (3) step();
        chk("rm_no_done", done_log.size() - d0, 0);
        a0 = addr_log.size(); s0 = sec_log.size(); d0 = done_log.size();
        run_row(16'd0, 0);
        chk("rm_new_addr0", addr_log[a0], 0);
        chk("rm_new_sec0", sec_log[s0], mem[0]);
        chk("rm_new_done", done_log[d0], 97);

        // back-to-back rows with start held high
        a0 = addr_log.size(); d0 = done_log.size(); f0 = fetch_log.size();
        base_address = 16'd0;
        start = 1'b1;
        step();
        base_address = 16'd32;
        fin = 1'b0;
        for (int c = 0; c < 500 && !fin; c++) begin
            step();
            fin = fetch_log.size() > f0 + 32;
        end
        start = 1'b0;
        fin = 1'b0;
        for (int c = 0; c < 500 && !fin; c++) begin
            step();
            fin = done_log.size() == d0 + 2 && !busy;
        end
        chk("b2b_finished", fin, 1);
        chk("b2b_gap", fetch_log[f0 + 32] - fetch_log[f0], 98);
        chk("b2b_addr32", addr_log[a0 + 32], 32);
        chk("b2b_addr63", addr_log[a0 + 63], 63);
        chk("b2b_done2", done_log[d0 + 1], 97);

        // random rows
        for (int r = 0; r < 4; r++) run_row(16'($urandom), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
